// File: rtl/dhcp_vlg_tx.sv
// dhcp_vlg_tx
// Serializes one DHCP client message into a byte stream for the UDP TX path.
// The frame is the pre-formatted BOOTP header plus magic cookie, then the options
// 53, 50, 54, 61, 12 and 55 in that fixed order (absent ones are skipped), then
// END (0xFF), then zero padding up to MIN_LEN bytes.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   dhcp_val          send request; accepted only while idle
//   dhcp_hdr          HDR_LEN header bytes; byte [HDR_LEN-1] goes out first
//   opt_pres          option present flags {list55, host12, cli61, srv54, req50}
//   opt_*             option values, latched together with dhcp_hdr
//   busy / done       frame in progress / one-cycle completion pulse
//   udp_len           total payload length (valid while busy)
//   udp_src_port/dst  constant 68 / 67
//   udp_dat/val/sof/eof, udp_rdy   byte stream with valid/ready handshake
module dhcp_vlg_tx #(
  parameter int HDR_LEN     = 240,
  parameter int MAX_OPT_PLD = 16,
  parameter int MIN_LEN     = 300
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dhcp_val,
  input  logic [HDR_LEN*8-1:0]     dhcp_hdr,
  input  logic [4:0]               opt_pres,
  input  logic [7:0]               opt_msg_type,
  input  logic [31:0]              opt_req_ip,
  input  logic [31:0]              opt_srv_id,
  input  logic [55:0]              opt_cli_id,
  input  logic [MAX_OPT_PLD*8-1:0] opt_hostname,
  input  logic [7:0]               opt_hostname_len,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              udp_len,
  output logic [15:0]              udp_src_port,
  output logic [15:0]              udp_dst_port,
  output logic [7:0]               udp_dat,
  output logic                     udp_val,
  output logic                     udp_sof,
  output logic                     udp_eof,
  input  logic                     udp_rdy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_HDR, S_OPT_KIND, S_OPT_LEN, S_OPT_DATA, S_END, S_PAD
  } state_t;

  // Option slot indices: 0=53 1=50 2=54 3=61 4=12 5=55; 6 means "no more options".
  localparam logic [2:0] OPT_NONE = 3'd6;

  state_t                   r_state, w_next;
  logic [HDR_LEN*8-1:0]     r_hdr;
  logic [4:0]               r_pres;
  logic [7:0]               r_msg;
  logic [31:0]              r_ip;
  logic [31:0]              r_sid;
  logic [55:0]              r_cli;
  logic [MAX_OPT_PLD*8-1:0] r_host;
  logic [7:0]               r_hl;
  logic [15:0]              r_len;
  logic [15:0]              r_cnt;
  logic [7:0]               r_idx;
  logic [2:0]               r_opt;
  logic                     r_done;

  logic                     w_start, w_hs, w_last, w_host_en, w_opt_last;
  logic [5:0]               w_en;
  logic [2:0]               w_nxt_opt;
  logic [7:0]               w_hl_in, w_optlen, w_rev, w_code, w_odat;
  logic [15:0]              w_hidx, w_opt_bytes, w_tot;

  // Next enabled option slot strictly after cur, or OPT_NONE.
  function automatic logic [2:0] next_opt(input logic [2:0] cur, input logic [5:0] en);
    logic [2:0] nxt;
    nxt = OPT_NONE;
    for (int i = 5; i >= 0; i--)
      if (i > int'(cur) && en[i]) nxt = 3'(i);
    return nxt;
  endfunction

  // A request arriving in the same cycle as done is dropped, so a new frame
  // starts in the cycle after done at the earliest.
  assign w_start   = (r_state == S_IDLE) && dhcp_val && !r_done;
  assign w_hs      = udp_val && udp_rdy;
  assign w_last    = (r_cnt == r_len - 16'd1);
  assign w_hl_in   = (opt_hostname_len > 8'(MAX_OPT_PLD)) ? 8'(MAX_OPT_PLD) : opt_hostname_len;
  assign w_host_en = r_pres[3] && (r_hl != 8'd0);
  assign w_en      = {r_pres[4], w_host_en, r_pres[2], r_pres[1], r_pres[0], 1'b1};
  assign w_nxt_opt = next_opt(r_opt, w_en);

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign udp_len      = r_len;
  assign udp_src_port = 16'd68;
  assign udp_dst_port = 16'd67;

  // Option code, length and the payload byte selected by r_idx.
  always_comb begin
    w_code   = 8'h00;
    w_optlen = 8'd0;
    case (r_opt)
      3'd0: begin w_code = 8'd53; w_optlen = 8'd1; end
      3'd1: begin w_code = 8'd50; w_optlen = 8'd4; end
      3'd2: begin w_code = 8'd54; w_optlen = 8'd4; end
      3'd3: begin w_code = 8'd61; w_optlen = 8'd7; end
      3'd4: begin w_code = 8'd12; w_optlen = r_hl; end
      3'd5: begin w_code = 8'd55; w_optlen = 8'd4; end
      default: ;
    endcase
  end

  // Payload goes out highest byte index first, so the byte index is L-1-r_idx.
  assign w_rev      = w_optlen - 8'd1 - r_idx;
  assign w_opt_last = (r_idx == w_optlen - 8'd1);
  assign w_hidx     = 16'(HDR_LEN - 1) - r_cnt;

  always_comb begin
    w_odat = 8'h00;
    case (r_opt)
      3'd0: w_odat = r_msg;
      3'd1: w_odat = 8'(r_ip  >> {w_rev, 3'b000});
      3'd2: w_odat = 8'(r_sid >> {w_rev, 3'b000});
      3'd3: w_odat = 8'(r_cli >> {w_rev, 3'b000});
      3'd4: w_odat = 8'(r_host >> {w_rev, 3'b000});
      3'd5: begin
        case (w_rev)
          8'd3:    w_odat = 8'd1;
          8'd2:    w_odat = 8'd3;
          8'd1:    w_odat = 8'd6;
          8'd0:    w_odat = 8'd51;
          default: w_odat = 8'd0;
        endcase
      end
      default: ;
    endcase
  end

  // Option area: 53 (3 bytes) + END (1 byte) are always present.
  always_comb begin
    w_opt_bytes = 16'd4
                + (r_pres[0] ? 16'd6 : 16'd0)
                + (r_pres[1] ? 16'd6 : 16'd0)
                + (r_pres[2] ? 16'd9 : 16'd0)
                + (w_host_en ? (16'd2 + {8'd0, r_hl}) : 16'd0)
                + (r_pres[4] ? 16'd6 : 16'd0);
    w_tot = 16'(HDR_LEN) + w_opt_bytes;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and stream outputs; outputs depend only on registered state,
  // so they hold still while the sink stalls.
  always_comb begin
    w_next  = r_state;
    udp_val = 1'b0;
    udp_dat = 8'h00;
    udp_sof = 1'b0;
    udp_eof = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_CALC;
      S_CALC: w_next = S_HDR;
      S_HDR: begin
        udp_val = 1'b1;
        udp_dat = 8'(r_hdr >> {w_hidx, 3'b000});
        udp_sof = (r_cnt == 16'd0);
        if (w_hs && r_cnt == 16'(HDR_LEN - 1)) w_next = S_OPT_KIND;
      end
      S_OPT_KIND: begin
        udp_val = 1'b1;
        udp_dat = w_code;
        if (w_hs) w_next = S_OPT_LEN;
      end
      S_OPT_LEN: begin
        udp_val = 1'b1;
        udp_dat = w_optlen;
        if (w_hs) w_next = S_OPT_DATA;
      end
      S_OPT_DATA: begin
        udp_val = 1'b1;
        udp_dat = w_odat;
        if (w_hs && w_opt_last) w_next = (w_nxt_opt == OPT_NONE) ? S_END : S_OPT_KIND;
      end
      S_END: begin
        udp_val = 1'b1;
        udp_dat = 8'hFF;
        udp_eof = w_last;
        if (w_hs) w_next = w_last ? S_IDLE : S_PAD;
      end
      S_PAD: begin
        udp_val = 1'b1;
        udp_eof = w_last;
        if (w_hs && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latched request: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_hdr  <= dhcp_hdr;
      r_pres <= opt_pres;
      r_msg  <= opt_msg_type;
      r_ip   <= opt_req_ip;
      r_sid  <= opt_srv_id;
      r_cli  <= opt_cli_id;
      r_host <= opt_hostname;
      r_hl   <= w_hl_in;
    end
  end

  // Counters, length and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= 16'd0;
      r_cnt  <= 16'd0;
      r_idx  <= 8'd0;
      r_opt  <= 3'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_hs && w_last;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 16'd0;
          r_idx <= 8'd0;
          r_opt <= 3'd0;
        end
        S_CALC: r_len <= (w_tot < 16'(MIN_LEN)) ? 16'(MIN_LEN) : w_tot;
        default: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 16'd1;
            if (r_state == S_OPT_DATA) begin
              if (w_opt_last) begin
                r_idx <= 8'd0;
                r_opt <= w_nxt_opt;
              end else begin
                r_idx <= r_idx + 8'd1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dhcp_vlg_tx.sv
module tb_dhcp_vlg_tx;
  localparam int HDR_LEN = 240, MAX_OPT_PLD = 16, MIN_LEN = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     dhcp_val = 1'b0;
  logic [HDR_LEN*8-1:0]     dhcp_hdr;
  logic [4:0]               opt_pres = '0;
  logic [7:0]               opt_msg_type = '0;
  logic [31:0]              opt_req_ip = '0, opt_srv_id = '0;
  logic [55:0]              opt_cli_id = '0;
  logic [MAX_OPT_PLD*8-1:0] opt_hostname = '0;
  logic [7:0]               opt_hostname_len = '0;
  logic                     busy, done, udp_val, udp_sof, udp_eof;
  logic [15:0]              udp_len, udp_src_port, udp_dst_port;
  logic [7:0]               udp_dat;
  logic                     udp_rdy = 1'b1;

  dhcp_vlg_tx #(.HDR_LEN(HDR_LEN), .MAX_OPT_PLD(MAX_OPT_PLD), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst(rst), .dhcp_val(dhcp_val), .dhcp_hdr(dhcp_hdr),
    .opt_pres(opt_pres), .opt_msg_type(opt_msg_type), .opt_req_ip(opt_req_ip),
    .opt_srv_id(opt_srv_id), .opt_cli_id(opt_cli_id), .opt_hostname(opt_hostname),
    .opt_hostname_len(opt_hostname_len), .busy(busy), .done(done), .udp_len(udp_len),
    .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port), .udp_dat(udp_dat),
    .udp_val(udp_val), .udp_sof(udp_sof), .udp_eof(udp_eof), .udp_rdy(udp_rdy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sink: captures handshaken bytes, checks stall stability and the done pulse.
  logic [7:0] cap[$];
  logic [7:0] exq[$];
  logic [7:0] ref_q[$];
  int  sof_cnt = 0, eof_cnt = 0, eof_pos = -1, done_cnt = 0;
  bit  rand_rdy = 1'b0, prev_stall = 1'b0, chk_done = 1'b0;
  logic [7:0] pd;
  logic ps, pe;

  always @(negedge clk) begin
    if (chk_done) begin
      chk_done = 1'b0;
      check("done_after_eof {done,val,busy}", {29'd0, done, udp_val, busy}, 32'b100);
    end
    if (done) done_cnt++;
    if (prev_stall && udp_val) begin
      check("stall_dat", {24'd0, udp_dat}, {24'd0, pd});
      check("stall_sof", {31'd0, udp_sof}, {31'd0, ps});
      check("stall_eof", {31'd0, udp_eof}, {31'd0, pe});
    end
    udp_rdy = rand_rdy ? ($urandom_range(0, 99) >= 30) : 1'b1;
    if (udp_val && udp_rdy) begin
      cap.push_back(udp_dat);
      if (udp_sof) begin
        sof_cnt++;
        check("sof_position", cap.size() - 1, 0);
      end
      if (udp_eof) begin
        eof_cnt++;
        eof_pos = cap.size() - 1;
        chk_done = 1'b1;
      end
    end
    prev_stall = udp_val && !udp_rdy;
    pd = udp_dat;
    ps = udp_sof;
    pe = udp_eof;
  end

  task automatic reset_mon();
    cap.delete();
    sof_cnt = 0; eof_cnt = 0; eof_pos = -1; done_cnt = 0;
  endtask

  // Reference frame built from the current bench inputs.
  task automatic build_exp();
    int hl;
    exq.delete();
    for (int i = HDR_LEN - 1; i >= 0; i--) exq.push_back(dhcp_hdr[i*8 +: 8]);
    exq.push_back(8'h35); exq.push_back(8'h01); exq.push_back(opt_msg_type);
    if (opt_pres[0]) begin
      exq.push_back(8'h32); exq.push_back(8'h04);
      for (int k = 3; k >= 0; k--) exq.push_back(opt_req_ip[k*8 +: 8]);
    end
    if (opt_pres[1]) begin
      exq.push_back(8'h36); exq.push_back(8'h04);
      for (int k = 3; k >= 0; k--) exq.push_back(opt_srv_id[k*8 +: 8]);
    end
    if (opt_pres[2]) begin
      exq.push_back(8'h3D); exq.push_back(8'h07);
      for (int k = 6; k >= 0; k--) exq.push_back(opt_cli_id[k*8 +: 8]);
    end
    hl = (int'(opt_hostname_len) > MAX_OPT_PLD) ? MAX_OPT_PLD : int'(opt_hostname_len);
    if (opt_pres[3] && hl > 0) begin
      exq.push_back(8'h0C); exq.push_back(8'(hl));
      for (int k = hl - 1; k >= 0; k--) exq.push_back(opt_hostname[k*8 +: 8]);
    end
    if (opt_pres[4]) begin
      exq.push_back(8'h37); exq.push_back(8'h04); exq.push_back(8'd1);
      exq.push_back(8'd3);  exq.push_back(8'd6);  exq.push_back(8'd51);
    end
    exq.push_back(8'hFF);
    while (exq.size() < MIN_LEN) exq.push_back(8'h00);
  endtask

  task automatic start_frame();
    @(posedge clk); #1 dhcp_val = 1'b1;
    @(posedge clk); #1 dhcp_val = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
    repeat (5) @(posedge clk);
    #1 check({tag, "_single_done"}, done_cnt, 1);
  endtask

  task automatic cmp_frame(input string tag, input int exp_len);
    int bad, first;
    bad = 0; first = -1;
    check({tag, "_size"}, cap.size(), exq.size());
    check({tag, "_size_vs_len"}, cap.size(), exp_len);
    for (int i = 0; i < exq.size(); i++)
      if (i >= cap.size() || cap[i] !== exq[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    if (bad != 0) $display("first differing byte index %0d", first);
    check({tag, "_bytes_differing"}, bad, 0);
    check({tag, "_sof_count"}, sof_cnt, 1);
    check({tag, "_eof_count"}, eof_cnt, 1);
    check({tag, "_eof_pos"}, eof_pos, exp_len - 1);
  endtask

  task automatic set_request();
    opt_pres = 5'b11111; opt_msg_type = 8'd3;
    opt_req_ip = 32'hC0A80164; opt_srv_id = 32'hC0A80101;
    opt_cli_id = 56'h0102AABBCCDDEE;
    opt_hostname = '0; opt_hostname[31:0] = "fpga"; opt_hostname_len = 8'd4;
  endtask

  logic [7:0] disc [19];
  logic [7:0] host12 [6];

  initial begin
    int n, bad;
    logic [7:0] sv_msg, rx_msg, rx_hl;
    logic [31:0] sv_ip, sv_sid, rx_ip, rx_sid;

    disc = '{8'h35, 8'h01, 8'h01, 8'h3D, 8'h07, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'hCC,
             8'hDD, 8'hEE, 8'h37, 8'h04, 8'h01, 8'h03, 8'h06, 8'h33, 8'hFF};
    host12 = '{8'h0C, 8'h04, 8'h66, 8'h70, 8'h67, 8'h61};
    for (int i = 0; i < HDR_LEN; i++) dhcp_hdr[i*8 +: 8] = 8'(i * 7 + 3);

    // Reset state
    #2;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_val", {31'd0, udp_val}, 0);
    check("rst_sof_eof", {30'd0, udp_sof, udp_eof}, 0);
    check("rst_dat", {24'd0, udp_dat}, 0);
    check("rst_len", {16'd0, udp_len}, 0);
    check("src_port", {16'd0, udp_src_port}, 68);
    check("dst_port", {16'd0, udp_dst_port}, 67);
    @(posedge clk); #1 rst = 1'b0;

    // DISCOVER, sink always ready
    opt_pres = 5'b10100; opt_msg_type = 8'd1; opt_cli_id = 56'h0102AABBCCDDEE;
    reset_mon(); build_exp();
    @(posedge clk); #1 dhcp_val = 1'b1;
    @(posedge clk); #1 dhcp_val = 1'b0;
    check("disc_busy_calc", {31'd0, busy}, 1);
    n = 1;
    while (!udp_val && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("disc_first_byte_latency", n, 2);
    check("disc_udp_len", {16'd0, udp_len}, 300);
    wait_done("disc");
    cmp_frame("disc", 300);
    for (int i = 0; i < 19; i++)
      if (cap.size() > 240 + i) check($sformatf("disc_byte%0d", 240 + i), {24'd0, cap[240+i]}, {24'd0, disc[i]});
    bad = 0;
    for (int i = 259; i < 300; i++) if (i < cap.size() && cap[i] != 8'h00) bad++;
    check("disc_pad_nonzero", bad, 0);

    // REQUEST with every option and hostname "fpga"
    set_request();
    reset_mon(); build_exp(); start_frame(); wait_done("req");
    cmp_frame("req", 300);
    check("req_len", {16'd0, udp_len}, 300);
    if (cap.size() > 276) begin
      check("req_byte240", {24'd0, cap[240]}, 32'h35);
      for (int i = 0; i < 6; i++)
        check($sformatf("req_opt12_byte%0d", i), {24'd0, cap[264+i]}, {24'd0, host12[i]});
      check("req_end_at_276", {24'd0, cap[276]}, 32'hFF);
    end
    ref_q = cap;

    // Hostname longer than MAX_OPT_PLD is clipped to 16 bytes
    for (int i = 0; i < MAX_OPT_PLD; i++) opt_hostname[i*8 +: 8] = 8'(8'h40 + i);
    opt_hostname_len = 8'd40;
    reset_mon(); build_exp(); start_frame(); wait_done("hlong");
    cmp_frame("hlong", 300);
    if (cap.size() > 282) begin
      check("hlong_len_byte", {24'd0, cap[265]}, 32'h10);
      check("hlong_first_pld", {24'd0, cap[266]}, 32'h4F);
      check("hlong_opt55_after", {24'd0, cap[282]}, 32'h37);
    end

    // Zero-length hostname omits option 12
    opt_hostname_len = 8'd0;
    reset_mon(); build_exp(); start_frame(); wait_done("hzero");
    cmp_frame("hzero", 300);
    if (cap.size() > 264) check("hzero_byte264_is_55", {24'd0, cap[264]}, 32'h37);

    // Random backpressure, ~30% stalls: same frame as the ready run
    set_request();
    rand_rdy = 1'b1;
    reset_mon(); build_exp(); start_frame(); wait_done("stall");
    rand_rdy = 1'b0;
    cmp_frame("stall", 300);
    bad = 0;
    for (int i = 0; i < ref_q.size(); i++) if (i >= cap.size() || cap[i] !== ref_q[i]) bad++;
    check("stall_vs_ready_run", bad, 0);

    // Reset after 120 bytes abandons the frame
    reset_mon(); start_frame();
    n = 0;
    while (cap.size() < 120 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_120", (cap.size() >= 120) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    check("abort_val_low", {31'd0, udp_val}, 0);
    check("abort_busy_low", {31'd0, busy}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_eof", eof_cnt, 0);
    reset_mon(); build_exp(); start_frame(); wait_done("after_abort");
    cmp_frame("after_abort", 300);

    // dhcp_val during busy is ignored; loopback parse of the frame
    set_request();
    sv_msg = opt_msg_type; sv_ip = opt_req_ip; sv_sid = opt_srv_id;
    reset_mon(); build_exp(); start_frame();
    repeat (10) @(posedge clk);
    #1;
    opt_msg_type = 8'd7; opt_req_ip = 32'h01020304; opt_srv_id = 32'h05060708;
    opt_hostname_len = 8'd2;
    dhcp_val = 1'b1;
    repeat (3) @(posedge clk);
    #1 dhcp_val = 1'b0;
    wait_done("ignore");
    repeat (40) @(posedge clk);
    #1;
    check("ignore_busy_after", {31'd0, busy}, 0);
    check("ignore_one_done", done_cnt, 1);
    cmp_frame("ignore", 300);
    rx_msg = 8'h00; rx_ip = 32'h0; rx_sid = 32'h0; rx_hl = 8'h00;
    n = 240;
    while (n + 1 < cap.size() && cap[n] != 8'hFF) begin
      if (cap[n] == 8'd0) n++;
      else begin
        if (cap[n] == 8'd53) rx_msg = cap[n+2];
        if (cap[n] == 8'd50) rx_ip  = {cap[n+2], cap[n+3], cap[n+4], cap[n+5]};
        if (cap[n] == 8'd54) rx_sid = {cap[n+2], cap[n+3], cap[n+4], cap[n+5]};
        if (cap[n] == 8'd12) rx_hl  = cap[n+1];
        n = n + 2 + int'(cap[n+1]);
      end
    end
    check("loop_msg_type", {24'd0, rx_msg}, {24'd0, sv_msg});
    check("loop_req_ip", rx_ip, sv_ip);
    check("loop_srv_id", rx_sid, sv_sid);
    check("loop_hostname_len", {24'd0, rx_hl}, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
